imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the 19-bit instruction memory. Receives a program image as a byte stream and writes 19-bit instruction words into a writable instruction RAM, starting at address 0.
- Holds the processor in reset (cpu_hold) while the image is being written. Validates the image with a length header, format checks and an 8-bit checksum.
- Sits between the host byte link (UART receiver or test bench) and the instruction RAM write port. The processor's fetch port remains the reader.

Parameters:
- ADDR_W, 12, instruction address width; also the width of the word-count field
- INST_W, 19, instruction word width
- BYTES_PER_WORD, 3, stream bytes per instruction (fixed by INST_W ≤ 24)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid; a byte is consumed when rx_valid & rx_ready
- rx_ready  out  1  loader can accept a byte
- wr_en  out  1  instruction RAM write strobe
- wr_addr  out  ADDR_W  instruction RAM write address
- wr_data  out  INST_W  instruction RAM write data
- cpu_hold  out  1  processor reset request
- busy  out  1  load in progress
- done  out  1  sticky: last load succeeded
- err  out  1  sticky: last load failed
- err_code  out  2  01 = bad length byte, 10 = bad word byte, 11 = checksum mismatch, 00 = none

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0 except cpu_hold=1. The processor does not run before the first successful load. Asserting reset mid-load aborts it; RAM contents already written stay as they are.
- Stream format, big-endian:
  - LEN_HI: bits 7:4 must be 0; bits 3:0 are N[11:8].
  - LEN_LO: N[7:0].
  - N words of 3 bytes each: byte0 bits 7:3 must be 0, byte0 bits 2:0 = inst[18:16]; byte1 = inst[15:8]; byte2 = inst[7:0].
  - CSUM: equals the mod-256 sum of all 3N word bytes. Header bytes are excluded.
- States: IDLE → (start) LEN_HI → LEN_LO → (N=0 ? CSUM : W0) → W1 → W2 → WRITE → (more words ? W0 : CSUM) → DONE | ERR.
- On accepting start: clear done, err and err_code; clear the checksum accumulator; set wr_addr=0; assert cpu_hold=1 and busy=1.
- rx_ready=1 only in LEN_HI, LEN_LO, W0, W1, W2 and CSUM. In all other states it is 0. A byte is consumed only on a cycle where rx_valid & rx_ready. rx_valid gaps of any length are allowed.
- WRITE lasts exactly one cycle:
  - wr_en=1, wr_data = the assembled word, wr_addr = the current index.
  - On the next cycle wr_addr increments and wr_en=0.
  - The write latency from accepting byte2 to wr_en is 1 cycle.
  - wr_en is never asserted in any other state.
- Word counter: counts the words written and compares against N. With N=4095 the last write is to address 4094 and wr_addr never wraps. N=0 writes nothing.
- Checksum: an 8-bit accumulator that wraps mod 256 and adds every accepted word byte.
- Error checks (state → ERR on the cycle after the offending byte is accepted):
  - LEN_HI with bits 7:4 ≠ 0 → err_code=01.
  - W0 with bits 7:3 ≠ 0 → err_code=10. No write is issued for that word.
  - CSUM byte ≠ accumulator → err_code=11.
- DONE: done=1, busy=0, cpu_hold=0 (processor released on the same cycle DONE is entered).
- ERR: err=1, busy=0, cpu_hold stays 1. Words already written are not rolled back.
- start while busy is ignored. start in DONE or ERR restarts a load and re-asserts cpu_hold.
- start and rx_valid in the same cycle while in IDLE: start is taken and the byte is not consumed, because rx_ready was 0.

Test Plan:
- Reset, then stream 00 02 | 07 00 10 | 04 00 00 | 1B → writes addr0=0x70010 (jmp 16) and addr1=0x40000; 0x07+0x10+0x04=0x1B; done=1, cpu_hold falls with DONE, wr_en high for exactly 2 cycles.
- Stream 00 00 00 → no wr_en; done=1; err=0.
- Stream 10 ... → err=1, err_code=01, rx_ready=0, cpu_hold=1, no writes.
- Stream 00 01 | 08 00 00 → err_code=10 after byte 08; no wr_en.
- Valid 2-word image with checksum 0x1C → both words written, then err_code=11, done=0, cpu_hold=1.
- Insert 5-cycle rx_valid gaps and a start pulse mid-load → identical writes, start ignored. Pull rst_n low after word 1 → immediate IDLE, cpu_hold=1, busy=0, no further writes.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader for the 19-bit instruction RAM: parses a length header, N big-endian
// words and a trailing checksum, writing each word as it completes while holding the CPU in reset.
module imem_loader #(
  parameter int ADDR_W         = 12,
  parameter int INST_W         = 19,
  parameter int BYTES_PER_WORD = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [INST_W-1:0] wr_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  // Payload bits carried by the first byte of a word, and length bits carried by LEN_HI.
  localparam int HI_W     = INST_W - 8 * (BYTES_PER_WORD - 1);
  localparam int LEN_HI_W = ADDR_W - 8;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN  = 2'b01;
  localparam logic [1:0] ERR_WORD = 2'b10;
  localparam logic [1:0] ERR_CSUM = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_W0,
    S_W1,
    S_W2,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   len_reg;
  logic [HI_W-1:0]     word_hi_reg;
  logic [7:0]          word_mid_reg;
  logic [7:0]          csum_reg;
  logic                wr_en_reg;
  logic [ADDR_W-1:0]   wr_addr_reg;
  logic [INST_W-1:0]   wr_data_reg;
  logic                cpu_hold_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                err_reg;
  logic [1:0]          err_code_reg;

  logic                take;
  logic [ADDR_W-1:0]   len_full;
  logic [ADDR_W-1:0]   addr_inc;

  always_comb begin
    rx_ready = 1'b0;
    case (state_reg)
      S_LEN_HI, S_LEN_LO, S_W0, S_W1, S_W2, S_CSUM: rx_ready = 1'b1;
      default:                                      rx_ready = 1'b0;
    endcase
  end

  assign take     = rx_valid & rx_ready;
  assign len_full = {len_reg[ADDR_W-1:8], rx_data};
  assign addr_inc = wr_addr_reg + 1'b1;

  assign wr_en    = wr_en_reg;
  assign wr_addr  = wr_addr_reg;
  assign wr_data  = wr_data_reg;
  assign cpu_hold = cpu_hold_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign err_code = err_code_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      word_hi_reg  <= '0;
      word_mid_reg <= '0;
      csum_reg     <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      cpu_hold_reg <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= ERR_NONE;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_reg    <= S_LEN_HI;
            csum_reg     <= '0;
            wr_addr_reg  <= '0;
            cpu_hold_reg <= 1'b1;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
          end
        end

        S_LEN_HI: begin
          if (take) begin
            if (|rx_data[7:LEN_HI_W]) begin
              state_reg    <= S_ERR;
              busy_reg     <= 1'b0;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_LEN;
            end else begin
              len_reg[ADDR_W-1:8] <= rx_data[LEN_HI_W-1:0];
              state_reg           <= S_LEN_LO;
            end
          end
        end

        S_LEN_LO: begin
          if (take) begin
            len_reg[7:0] <= rx_data;
            // An empty image goes straight to the checksum byte, which must then be zero.
            state_reg    <= (len_full == '0) ? S_CSUM : S_W0;
          end
        end

        S_W0: begin
          if (take) begin
            if (|rx_data[7:HI_W]) begin
              state_reg    <= S_ERR;
              busy_reg     <= 1'b0;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_WORD;
            end else begin
              word_hi_reg <= rx_data[HI_W-1:0];
              csum_reg    <= csum_reg + rx_data;
              state_reg   <= S_W1;
            end
          end
        end

        S_W1: begin
          if (take) begin
            word_mid_reg <= rx_data;
            csum_reg     <= csum_reg + rx_data;
            state_reg    <= S_W2;
          end
        end

        S_W2: begin
          if (take) begin
            wr_data_reg <= {word_hi_reg, word_mid_reg, rx_data};
            wr_en_reg   <= 1'b1;
            csum_reg    <= csum_reg + rx_data;
            state_reg   <= S_WRITE;
          end
        end

        S_WRITE: begin
          // wr_addr doubles as the count of words written; it stops at N, never wrapping.
          wr_en_reg   <= 1'b0;
          wr_addr_reg <= addr_inc;
          state_reg   <= (addr_inc == len_reg) ? S_CSUM : S_W0;
        end

        S_CSUM: begin
          if (take) begin
            busy_reg <= 1'b0;
            if (rx_data == csum_reg) begin
              state_reg    <= S_DONE;
              done_reg     <= 1'b1;
              cpu_hold_reg <= 1'b0;
            end else begin
              state_reg    <= S_ERR;
              err_reg      <= 1'b1;
              err_code_reg <= ERR_CSUM;
            end
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images from the test plan plus randomized
// images (with injected faults) checked against a stream-parsing reference model.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [18:0] wr_data;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;
  int load_no = 0;
  bit aborted;

  logic [30:0] exp_wr[$];
  logic [30:0] act_wr[$];

  imem_loader #(.ADDR_W(12), .INST_W(19), .BYTES_PER_WORD(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  // Every cycle with wr_en high is logged, so a stretched strobe shows up as an extra write.
  always @(negedge clk) begin
    if (rst_n && wr_en) act_wr.push_back({wr_addr, wr_data});
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: walks the byte stream by the format rules and predicts writes and outcome.
  task automatic model_run(input bq_t s, output int used, output bit m_done, output logic [1:0] m_code);
    int n;
    int idx;
    logic [7:0] sum;
    logic [7:0] b0;
    logic [7:0] hdr;
    exp_wr.delete();
    m_done = 1'b0;
    m_code = 2'b00;
    hdr = s[0];
    if (hdr[7:4] != 4'h0) begin
      used = 1;
      m_code = 2'b01;
      return;
    end
    n = hdr[3:0] * 256 + s[1];
    sum = 8'h00;
    idx = 2;
    for (int w = 0; w < n; w++) begin
      b0 = s[idx];
      if (b0[7:3] != 5'd0) begin
        used = idx + 1;
        m_code = 2'b10;
        return;
      end
      sum = sum + s[idx] + s[idx+1] + s[idx+2];
      exp_wr.push_back({12'(w), b0[2:0], s[idx+1], s[idx+2]});
      idx += 3;
    end
    used = idx + 1;
    if (s[idx] == sum) m_done = 1'b1;
    else m_code = 2'b11;
  endtask

  // fault: 0 none, 1 bad length byte, 2 bad first byte in one word, 3 wrong checksum
  task automatic gen_stream(input int n, input int fault, output bq_t s);
    logic [7:0] sum;
    logic [7:0] b;
    int bad_k;
    s.delete();
    sum = 8'h00;
    bad_k = (n > 0) ? int'($urandom_range(n - 1)) : 0;
    b = {4'h0, 4'(n >> 8)};
    if (fault == 1) b[7:4] = 4'($urandom_range(1, 15));
    s.push_back(b);
    s.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      b = {5'd0, 3'($urandom)};
      if (fault == 2 && k == bad_k) b[7:3] = 5'($urandom_range(1, 31));
      s.push_back(b);
      sum = sum + b;
      b = 8'($urandom);
      s.push_back(b);
      sum = sum + b;
      b = 8'($urandom);
      s.push_back(b);
      sum = sum + b;
    end
    if (fault == 3) sum = sum + 8'($urandom_range(1, 255));
    s.push_back(sum);
  endtask

  // Called and returns at a falling edge; the byte is consumed on the rising edge in between.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit mid_start);
    int wait_cnt;
    repeat (gap) @(negedge clk);
    if (mid_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    rx_data = b;
    rx_valid = 1'b1;
    wait_cnt = 0;
    while (!rx_ready && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (!rx_ready) begin
      chk("rdy_timeout", 32'd0, 32'd1);
      aborted = 1'b1;
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic run_load(input bq_t s, input int max_gap, input bit mid_start_en, input bit start_with_byte);
    int used;
    bit m_done;
    logic [1:0] m_code;
    int pos;
    int nchk;
    model_run(s, used, m_done, m_code);
    act_wr.delete();
    aborted = 1'b0;
    load_no++;

    start = 1'b1;
    if (start_with_byte) begin
      rx_data = 8'hF0;
      rx_valid = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    rx_valid = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_hold", cpu_hold, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", err, 0);

    for (int i = 0; i < used; i++) begin
      send_byte(s[i], int'($urandom_range(max_gap)), mid_start_en && ($urandom_range(3) == 0));
      if (aborted) break;
      pos = i - 2;
      if (pos >= 0 && pos % 3 == 2 && pos / 3 < exp_wr.size()) begin
        chk("wr_lat", wr_en, 1);
        chk("wr_lat_addr", wr_addr, pos / 3);
      end else if (i < used - 1) begin
        chk("hold_mid", cpu_hold, 1);
      end
    end

    chk("end_done", done, m_done);
    chk("end_err", err, !m_done);
    chk("end_code", err_code, m_code);
    chk("end_hold", cpu_hold, !m_done);
    chk("end_busy", busy, 0);
    chk("end_ready", rx_ready, 0);
    chk("end_wr_en", wr_en, 0);
    chk("wr_count", act_wr.size(), exp_wr.size());
    nchk = (act_wr.size() < exp_wr.size()) ? act_wr.size() : exp_wr.size();
    for (int i = 0; i < nchk; i++) chk("wr_word", act_wr[i], exp_wr[i]);
    $display("[TB] load %0d: bytes=%0d writes=%0d/%0d done=%0b err=%0b code=%0d",
             load_no, used, act_wr.size(), exp_wr.size(), done, err, err_code);
  endtask

  initial begin
    bq_t s;
    int n;
    int fault;

    repeat (3) @(negedge clk);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", rx_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_code", err_code, 0);
    chk("idle_addr", wr_addr, 0);

    // Two-word image; a byte presented alongside start must not be consumed.
    s = '{8'h00, 8'h02, 8'h07, 8'h00, 8'h10, 8'h04, 8'h00, 8'h00, 8'h1B};
    run_load(s, 0, 1'b0, 1'b1);
    chk("plan1_w0", act_wr.size() > 0 ? act_wr[0] : 31'h0, {12'd0, 19'h70010});
    s = '{8'h00, 8'h00, 8'h00};
    run_load(s, 0, 1'b0, 1'b0);
    s = '{8'h10, 8'h00};
    run_load(s, 0, 1'b0, 1'b0);
    s = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h00};
    run_load(s, 0, 1'b0, 1'b0);
    s = '{8'h00, 8'h02, 8'h07, 8'h00, 8'h10, 8'h04, 8'h00, 8'h00, 8'h1C};
    run_load(s, 0, 1'b0, 1'b0);
    s = '{8'h00, 8'h02, 8'h07, 8'h00, 8'h10, 8'h04, 8'h00, 8'h00, 8'h1B};
    run_load(s, 5, 1'b1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      n = int'($urandom_range(10));
      fault = int'($urandom_range(5));
      if (fault > 3) fault = 0;
      gen_stream(n, fault, s);
      run_load(s, 3, 1'b1, 1'b0);
    end

    // Largest image: last write lands on 4094.
    gen_stream(4095, 0, s);
    run_load(s, 0, 1'b0, 1'b0);
    chk("max_last_addr", act_wr.size() > 0 ? act_wr[act_wr.size()-1][30:19] : 12'h0, 12'd4094);

    // Reset in the middle of a load, after the first word has been written.
    act_wr.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = '{8'h00, 8'h02, 8'h03, 8'hAB, 8'hCD};
    aborted = 1'b0;
    for (int i = 0; i < s.size(); i++) send_byte(s[i], 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_hold", cpu_hold, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", rx_ready, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rx_data = 8'h01;
    rx_valid = 1'b1;
    repeat (6) @(negedge clk);
    rx_valid = 1'b0;
    chk("mid_rst_writes", act_wr.size(), 1);
    chk("mid_rst_word", act_wr.size() > 0 ? act_wr[0] : 31'h0, {12'd0, 19'h3ABCD});
    chk("mid_rst_idle_busy", busy, 0);
    $display("[TB] load %0d: reset mid-load, writes=%0d", ++load_no, act_wr.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
